// File: rtl/fpu_pkg.sv
// Shared FPU constants and types for the integer-to-float issue path.
package fpu_pkg;

  localparam int ITOF_LAT = 2;
  localparam int FP32_W   = 32;

  typedef logic [FP32_W-1:0] fp32_t;

  localparam fp32_t      FP32_ZERO     = 32'h0000_0000;
  localparam fp32_t      FP32_NEG_2P31 = 32'hCF00_0000;
  localparam logic [7:0] FP32_BIAS     = 8'd127;

endpackage

// File: rtl/itof.sv
// Combinational int32 -> float32 converter.
// Rounds half-up on the first dropped bit; the most negative int is special-cased.
module itof
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  output fp32_t       y
);

  logic        sign;
  logic [30:0] mag;
  logic [4:0]  msb;
  logic [23:0] frac;
  logic [30:0] body;

  always_comb begin
    sign = x[31];
    mag  = sign ? 31'(-x) : x[30:0];
    msb  = '0;
    for (int i = 0; i < 31; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    // Leading one lands on bit 30; mantissa is bits 29:7, round bit is bit 6.
    frac = 24'((mag << (5'd30 - msb)) >> 6);
    body = {FP32_BIAS + {3'b000, msb}, frac[23:1]} + {30'b0, frac[0]};
    if (x == 32'h0000_0000) begin
      y = FP32_ZERO;
    end else if (x == 32'h8000_0000) begin
      y = FP32_NEG_2P31;
    end else begin
      y = {sign, body};
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of valid, searching from ptr upward modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Walk the search order backwards so the nearest candidate to ptr wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % N_REQ]) begin
        idx   = ID_W'((int'(ptr) + k) % N_REQ);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/itof_arb.sv
// Round-robin shares one itof converter among N_REQ requesters through a 2-stage pipe.
// Accept -> result visible two edges later; req_ready drops only when both stages are stalled.
module itof_arb
  import fpu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [32*N_REQ-1:0] req_x,
  output logic [N_REQ-1:0]    req_ready,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ID_W-1:0]     resp_id,
  output fp32_t               resp_y,
  output logic                busy
);

  logic            s1_v;
  logic [ID_W-1:0] s1_id;
  logic [31:0]     s1_x;
  logic            s2_v;
  logic [ID_W-1:0] s2_id;
  fp32_t           s2_y;
  logic [ID_W-1:0] rr_ptr;

  logic            adv1;
  logic            adv2;
  logic            found;
  logic            accept;
  logic [ID_W-1:0] grant_idx;
  fp32_t           conv_y;

  assign adv2   = !s2_v || resp_ready;
  assign adv1   = !s1_v || adv2;
  // Gating with rstn keeps grants off while reset is held, even with requests pending.
  assign accept = found && adv1 && rstn;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (grant_idx),
    .found (found)
  );

  itof u_itof (
    .x (s1_x),
    .y (conv_y)
  );

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v   <= 1'b0;
      s1_id  <= '0;
      s1_x   <= '0;
      s2_v   <= 1'b0;
      s2_id  <= '0;
      s2_y   <= FP32_ZERO;
      rr_ptr <= '0;
    end else begin
      if (adv2) begin
        s2_v  <= s1_v;
        s2_id <= s1_id;
        s2_y  <= conv_y;
      end
      if (adv1) begin
        s1_v <= accept;
        if (accept) begin
          s1_id  <= grant_idx;
          s1_x   <= req_x[32*grant_idx +: 32];
          rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

  assign resp_valid = s2_v;
  assign resp_id    = s2_id;
  assign resp_y     = s2_y;
  assign busy       = s1_v || s2_v;

endmodule

// File: tb/tb_itof_arb.sv
// Directed and randomised checks of itof_arb against an arithmetic int->float model and per-id queues.
module tb_itof_arb;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   req_valid;
  logic [127:0] req_x;
  logic [3:0]   req_ready;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_y;
  logic         busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] expq [4][$];
  int          inflight;
  int          mptr;
  int          last_grant;
  int          nacc;
  logic [1:0]  hold_id;
  logic [31:0] hold_y;

  itof_arb #(.N_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact value scaled to 24 significant bits, rounded half-up on magnitude.
  function automatic logic [31:0] ref_itof(input logic [31:0] x);
    logic        s;
    logic [63:0] m;
    logic [63:0] r;
    int          p;
    int          sh;
    if (x == 32'h0) return 32'h0;
    s = x[31];
    m = s ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p <= 23) begin
      r = m << (23 - p);
    end else begin
      sh = p - 23;
      r  = (m + (64'd1 << (sh - 1))) >> sh;
      if (r == (64'd1 << 24)) begin
        r = r >> 1;
        p++;
      end
    end
    return {s, 8'(127 + p), r[22:0]};
  endfunction

  function automatic logic [3:0] model_rdy();
    int j;
    if (!rstn) return 4'b0000;
    if (inflight == 2 && !resp_ready) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      j = (mptr + k) % 4;
      if (req_valid[j]) return 4'(1 << j);
    end
    return 4'b0000;
  endfunction

  function automatic logic [31:0] pick_x();
    int v;
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: begin
        v = int'($urandom_range(0, 2000)) - 1000;
        return v;
      end
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) expq[i].delete();
    inflight   = 0;
    mptr       = 0;
    nacc       = 0;
    last_grant = -1;
  endtask

  // One clock: check grant and response at the falling edge, update the model, step past the rising edge.
  task automatic cyc();
    logic [3:0] er;
    @(negedge clk);
    last_grant = -1;
    er = model_rdy();
    chk("req_ready", req_ready, er);
    chk("busy", busy, 32'(inflight != 0));
    if (resp_valid && resp_ready) begin
      chk("resp_has_req", 32'(expq[resp_id].size() > 0), 1);
      if (expq[resp_id].size() > 0) chk("resp_y", resp_y, expq[resp_id].pop_front());
      inflight--;
    end
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        expq[i].push_back(ref_itof(req_x[32*i +: 32]));
        inflight++;
        nacc++;
        mptr       = (i + 1) % 4;
        last_grant = i;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    req_x      = '0;
    @(negedge clk);
    clear_model();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int k = 0; k < 20 && inflight != 0; k++) cyc();
    chk("drain_inflight", inflight, 0);
    for (int i = 0; i < 4; i++) chk("drain_queue", expq[i].size(), 0);
  endtask

  initial begin
    int k;
    logic [31:0] tbl [4];
    tbl[0] = 32'h40E0_0000;
    tbl[1] = 32'hC000_0000;
    tbl[2] = 32'h3F80_0000;
    tbl[3] = 32'hCF00_0000;

    // Reset state, with requests pending to confirm no grant while in reset.
    rstn       = 1'b0;
    req_valid  = 4'hF;
    req_x      = '0;
    resp_ready = 1'b1;
    #3;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_y", resp_y, 0);
    chk("rst_req_ready", req_ready, 0);
    do_reset();

    // 1: single request latency and values.
    resp_ready      = 1'b1;
    req_x[31:0]     = 32'd1;
    req_valid       = 4'b0001;
    cyc();
    req_valid       = '0;
    chk("t1_lat_early", resp_valid, 0);
    chk("t1_busy", busy, 1);
    cyc();
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_resp_y", resp_y, 32'h3F80_0000);
    chk("t1_resp_id", resp_id, 0);
    req_x[31:0] = 32'd0;
    req_valid   = 4'b0001;
    cyc();
    req_valid   = '0;
    cyc();
    chk("t1_zero_valid", resp_valid, 1);
    chk("t1_zero_y", resp_y, 32'h0);
    drain();

    // 2: fairness with all requesters active.
    do_reset();
    resp_ready      = 1'b1;
    req_x[31:0]     = 32'd7;
    req_x[63:32]    = 32'hFFFF_FFFE;
    req_x[95:64]    = 32'd1;
    req_x[127:96]   = 32'h8000_0000;
    req_valid       = 4'hF;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t2_grant", last_grant, i % 4);
      if (i >= 1) begin
        chk("t2_resp_id", resp_id, (i - 1) % 4);
        chk("t2_resp_y", resp_y, tbl[(i - 1) % 4]);
      end
    end
    drain();

    // 3: backpressure for five cycles while streaming six operations.
    do_reset();
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) req_x[32*i +: 32] = pick_x();
    req_valid = 4'hF;
    cyc();
    cyc();
    chk("t3_two_accepts", nacc, 2);
    chk("t3_resp_valid", resp_valid, 1);
    hold_id = resp_id;
    hold_y  = resp_y;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_ready_low", req_ready, 0);
      chk("t3_id_stable", resp_id, hold_id);
      chk("t3_y_stable", resp_y, hold_y);
    end
    resp_ready = 1'b1;
    k = 0;
    while (nacc < 6 && k < 20) begin
      cyc();
      k++;
    end
    req_valid = '0;
    chk("t3_six_accepts", nacc, 6);
    drain();

    // 4: sparse requests and pointer wrap.
    do_reset();
    resp_ready = 1'b1;
    req_x      = {32'd40, 32'd30, 32'd20, 32'd10};
    req_valid  = 4'b0100;
    cyc();
    chk("t4_grant2", last_grant, 2);
    req_valid = 4'b0010;
    cyc();
    chk("t4_wrap_grant1", last_grant, 1);
    req_valid = 4'b1100;
    cyc();
    chk("t4_grant2_first", last_grant, 2);
    req_valid = 4'b1000;
    cyc();
    chk("t4_grant3_next", last_grant, 3);
    drain();

    // 5: reset with both stages full.
    do_reset();
    resp_ready = 1'b0;
    req_x      = {32'd4, 32'd3, 32'd2, 32'd1};
    req_valid  = 4'hF;
    cyc();
    cyc();
    chk("t5_full_valid", resp_valid, 1);
    chk("t5_full_ready", req_ready, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_async_valid", resp_valid, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    clear_model();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    resp_ready   = 1'b1;
    req_x[63:32] = 32'd5;
    req_valid    = 4'b0010;
    cyc();
    req_valid = '0;
    cyc();
    chk("t5_first_valid", resp_valid, 1);
    chk("t5_first_id", resp_id, 1);
    chk("t5_first_y", resp_y, 32'h40A0_0000);
    drain();

    // 6: randomised valid/ready traffic against the scoreboard.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      req_valid  = 4'($urandom);
      resp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) req_x[32*i +: 32] = pick_x();
      cyc();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
